// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file scoreboard.
// The master side is the pipeline (decode and wbstage); the slave side is the register file.
interface regfile_scoreboard_if #(
   parameter int unsigned XLEN = 32
);
   logic [4:0]      rs1_addr_i;
   logic            rs1_used_i;
   logic [XLEN-1:0] rs1_data_o;
   logic [4:0]      rs2_addr_i;
   logic            rs2_used_i;
   logic [XLEN-1:0] rs2_data_o;
   logic            issue_valid_i;
   logic            issue_wr_i;
   logic [4:0]      issue_rd_i;
   logic            stall_o;
   logic            wb_valid_i;
   logic            wb_we_i;
   logic [4:0]      wb_rd_i;
   logic [XLEN-1:0] wb_data_i;
   logic            err_o;

   modport master (
      output rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
      output issue_valid_i, issue_wr_i, issue_rd_i,
      output wb_valid_i, wb_we_i, wb_rd_i, wb_data_i,
      input  rs1_data_o, rs2_data_o, stall_o, err_o
   );

   modport slave (
      input  rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
      input  issue_valid_i, issue_wr_i, issue_rd_i,
      input  wb_valid_i, wb_we_i, wb_rd_i, wb_data_i,
      output rs1_data_o, rs2_data_o, stall_o, err_o
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file x0..x31 with per-register in-flight write counters.
// Provides WB->read bypass, RAW and structural stall requests, and a sticky underflow error.
module regfile_scoreboard #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned MAX_INFLIGHT = 3
) (
   input logic                 clk_i,
   input logic                 rst_i,
   regfile_scoreboard_if.slave bus
);
   localparam int unsigned   CW     = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CW-1:0] MaxCnt = CW'(MAX_INFLIGHT);

   logic [XLEN-1:0] regs_q [32];
   logic [XLEN-1:0] regs_d [32];
   logic [CW-1:0]   cnt_q  [32];
   logic [CW-1:0]   cnt_d  [32];
   logic            err_q, err_d;

   logic wb_write, wb_retire;
   logic hazard_rs1, hazard_rs2, structural, stall, issue_acc;

   assign wb_write  = bus.wb_valid_i & bus.wb_we_i & (bus.wb_rd_i != 5'd0);
   assign wb_retire = bus.wb_valid_i & (bus.wb_rd_i != 5'd0);

   assign bus.rs1_data_o = (bus.rs1_addr_i == 5'd0) ? '0 :
                           (wb_write && bus.wb_rd_i == bus.rs1_addr_i) ? bus.wb_data_i :
                           regs_q[bus.rs1_addr_i];
   assign bus.rs2_data_o = (bus.rs2_addr_i == 5'd0) ? '0 :
                           (wb_write && bus.wb_rd_i == bus.rs2_addr_i) ? bus.wb_data_i :
                           regs_q[bus.rs2_addr_i];

   // A single outstanding producer retiring with data this cycle is covered by the bypass.
   assign hazard_rs1 = bus.rs1_used_i & (bus.rs1_addr_i != 5'd0) &
                       (cnt_q[bus.rs1_addr_i] != '0) &
                       ~((cnt_q[bus.rs1_addr_i] == CW'(1)) & wb_write &
                         (bus.wb_rd_i == bus.rs1_addr_i));
   assign hazard_rs2 = bus.rs2_used_i & (bus.rs2_addr_i != 5'd0) &
                       (cnt_q[bus.rs2_addr_i] != '0) &
                       ~((cnt_q[bus.rs2_addr_i] == CW'(1)) & wb_write &
                         (bus.wb_rd_i == bus.rs2_addr_i));

   assign structural = bus.issue_wr_i & (bus.issue_rd_i != 5'd0) &
                       (cnt_q[bus.issue_rd_i] == MaxCnt) &
                       ~(wb_retire & (bus.wb_rd_i == bus.issue_rd_i));

   assign stall       = bus.issue_valid_i & (hazard_rs1 | hazard_rs2 | structural);
   assign issue_acc   = bus.issue_valid_i & ~stall & bus.issue_wr_i & (bus.issue_rd_i != 5'd0);
   assign bus.stall_o = stall;
   assign bus.err_o   = err_q;

   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      if (wb_write) begin
         regs_d[bus.wb_rd_i] = bus.wb_data_i;
      end
      for (int r = 1; r < 32; r++) begin
         if (issue_acc && bus.issue_rd_i == 5'(r) &&
             !(wb_retire && bus.wb_rd_i == 5'(r))) begin
            cnt_d[r] = cnt_q[r] + CW'(1);
         end else if (wb_retire && bus.wb_rd_i == 5'(r) &&
                      !(issue_acc && bus.issue_rd_i == 5'(r))) begin
            if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - CW'(1);
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regs_q <= '{default: '0};
         cnt_q  <= '{default: '0};
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scenarios plus a randomized run against a queue-based in-flight model.
module tb_regfile_scoreboard;
   localparam int unsigned XLEN         = 32;
   localparam int unsigned MAX_INFLIGHT = 3;

   logic clk;
   logic rst;
   int   nchk = 0;
   int   nerr = 0;

   regfile_scoreboard_if #(.XLEN(XLEN)) bus ();

   regfile_scoreboard #(.XLEN(XLEN), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: architectural values plus an ordered list of outstanding destinations.
   logic [XLEN-1:0] m_reg [32];
   logic [4:0]      m_q [$];
   logic            m_err;

   function automatic int m_cnt(input logic [4:0] r);
      int c = 0;
      foreach (m_q[i]) if (m_q[i] == r) c++;
      return c;
   endfunction

   function automatic logic [XLEN-1:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return '0;
      if (bus.wb_valid_i && bus.wb_we_i && bus.wb_rd_i == a) return bus.wb_data_i;
      return m_reg[a];
   endfunction

   function automatic logic m_hazard(input logic used, input logic [4:0] a);
      int c = m_cnt(a);
      if (!used || a == 5'd0 || c == 0) return 1'b0;
      if (c == 1 && bus.wb_valid_i && bus.wb_we_i && bus.wb_rd_i == a) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic m_stall();
      logic st;
      st = bus.issue_wr_i && bus.issue_rd_i != 5'd0 &&
           m_cnt(bus.issue_rd_i) == int'(MAX_INFLIGHT) &&
           !(bus.wb_valid_i && bus.wb_rd_i == bus.issue_rd_i);
      return bus.issue_valid_i &&
             (m_hazard(bus.rs1_used_i, bus.rs1_addr_i) ||
              m_hazard(bus.rs2_used_i, bus.rs2_addr_i) || st);
   endfunction

   task automatic model_update();
      logic acc;
      logic consumed;
      int   idx;
      if (rst) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         m_q.delete();
         m_err = 1'b0;
         return;
      end
      acc = !m_stall() && bus.issue_valid_i && bus.issue_wr_i && bus.issue_rd_i != 5'd0;
      consumed = 1'b0;
      if (bus.wb_valid_i && bus.wb_rd_i != 5'd0) begin
         if (bus.wb_we_i) m_reg[bus.wb_rd_i] = bus.wb_data_i;
         idx = -1;
         foreach (m_q[i]) if (idx < 0 && m_q[i] == bus.wb_rd_i) idx = i;
         if (idx >= 0) m_q.delete(idx);
         else if (acc && bus.issue_rd_i == bus.wb_rd_i) consumed = 1'b1;
         else m_err = 1'b1;
      end
      if (acc && !consumed) m_q.push_back(bus.issue_rd_i);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rs1_addr_i = '0; bus.rs1_used_i = 1'b0;
      bus.rs2_addr_i = '0; bus.rs2_used_i = 1'b0;
      bus.issue_valid_i = 1'b0; bus.issue_wr_i = 1'b0; bus.issue_rd_i = '0;
      bus.wb_valid_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_rd_i = '0; bus.wb_data_i = '0;
   endtask

   task automatic issue(input logic [4:0] rd);
      bus.issue_valid_i = 1'b1; bus.issue_wr_i = 1'b1; bus.issue_rd_i = rd;
   endtask

   task automatic retire(input logic [4:0] rd, input logic we, input logic [XLEN-1:0] d);
      bus.wb_valid_i = 1'b1; bus.wb_we_i = we; bus.wb_rd_i = rd; bus.wb_data_i = d;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      bus.rs1_addr_i = 5'd5; bus.rs1_used_i = 1'b1;
      bus.rs2_addr_i = 5'd0; bus.rs2_used_i = 1'b1;
      #1;
      nchk++; if (bus.rs1_data_o !== '0) begin
         nerr++; $display("FAIL reset_rs1 got=%h exp=0", bus.rs1_data_o); end
      nchk++; if (bus.rs2_data_o !== '0) begin
         nerr++; $display("FAIL reset_rs2 got=%h exp=0", bus.rs2_data_o); end
      nchk++; if (bus.stall_o !== 1'b0) begin
         nerr++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
      nchk++; if (bus.err_o !== 1'b0) begin
         nerr++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
      step();
   endtask

   task automatic test_bypass();
      idle();
      issue(5'd3);
      step();
      idle();
      retire(5'd3, 1'b1, 32'hDEADBEEF);
      bus.rs1_addr_i = 5'd3;
      #1;
      nchk++; if (bus.rs1_data_o !== 32'hDEADBEEF) begin
         nerr++; $display("FAIL bypass_x3 got=%h exp=deadbeef", bus.rs1_data_o); end
      step();
      idle();
      bus.rs1_addr_i = 5'd3;
      #1;
      nchk++; if (bus.rs1_data_o !== 32'hDEADBEEF) begin
         nerr++; $display("FAIL stored_x3 got=%h exp=deadbeef", bus.rs1_data_o); end
      retire(5'd0, 1'b1, 32'h12345678);
      bus.rs2_addr_i = 5'd0;
      #1;
      nchk++; if (bus.rs2_data_o !== '0) begin
         nerr++; $display("FAIL x0_bypass got=%h exp=0", bus.rs2_data_o); end
      step();
      idle();
      #1;
      nchk++; if (bus.rs2_data_o !== '0) begin
         nerr++; $display("FAIL x0_stored got=%h exp=0", bus.rs2_data_o); end
      nchk++; if (bus.err_o !== 1'b0) begin
         nerr++; $display("FAIL x0_no_err got=%b exp=0", bus.err_o); end
   endtask

   task automatic test_raw();
      idle();
      issue(5'd7);
      step();
      idle();
      bus.issue_valid_i = 1'b1;
      bus.rs2_addr_i = 5'd7; bus.rs2_used_i = 1'b1;
      #1;
      nchk++; if (bus.stall_o !== 1'b1) begin
         nerr++; $display("FAIL raw_stall got=%b exp=1", bus.stall_o); end
      step();
      retire(5'd7, 1'b1, 32'h0000A5A5);
      #1;
      nchk++; if (bus.stall_o !== 1'b0) begin
         nerr++; $display("FAIL raw_release got=%b exp=0", bus.stall_o); end
      nchk++; if (bus.rs2_data_o !== 32'h0000A5A5) begin
         nerr++; $display("FAIL raw_bypass got=%h exp=0000a5a5", bus.rs2_data_o); end
      step();
      bus.wb_valid_i = 1'b0;
      #1;
      nchk++; if (bus.stall_o !== 1'b0) begin
         nerr++; $display("FAIL raw_cnt_zero got=%b exp=0", bus.stall_o); end
      idle();
      step();
   endtask

   task automatic test_struct();
      idle();
      for (int i = 0; i < 3; i++) begin
         issue(5'd9);
         #1;
         nchk++; if (bus.stall_o !== 1'b0) begin
            nerr++; $display("FAIL struct_fill%0d got=%b exp=0", i, bus.stall_o); end
         step();
      end
      #1;
      nchk++; if (bus.stall_o !== 1'b1) begin
         nerr++; $display("FAIL struct_full got=%b exp=1", bus.stall_o); end
      retire(5'd9, 1'b1, 32'h99);
      #1;
      nchk++; if (bus.stall_o !== 1'b0) begin
         nerr++; $display("FAIL struct_retire_accept got=%b exp=0", bus.stall_o); end
      step();
      bus.wb_valid_i = 1'b0;
      #1;
      nchk++; if (bus.stall_o !== 1'b1) begin
         nerr++; $display("FAIL struct_still_full got=%b exp=1", bus.stall_o); end
      idle();
      for (int i = 0; i < 3; i++) begin
         retire(5'd9, 1'b1, 32'(i));
         step();
      end
      idle();
      bus.issue_valid_i = 1'b1;
      bus.rs1_addr_i = 5'd9; bus.rs1_used_i = 1'b1;
      #1;
      nchk++; if (bus.stall_o !== 1'b0) begin
         nerr++; $display("FAIL struct_drained got=%b exp=0", bus.stall_o); end
      nchk++; if (bus.err_o !== 1'b0) begin
         nerr++; $display("FAIL struct_no_err got=%b exp=0", bus.err_o); end
      idle();
      step();
   endtask

   task automatic test_squash();
      idle();
      issue(5'd4);
      step();
      idle();
      retire(5'd4, 1'b1, 32'h44);
      step();
      idle();
      issue(5'd4);
      step();
      idle();
      retire(5'd4, 1'b0, 32'hBAD);
      bus.issue_valid_i = 1'b1;
      bus.rs1_addr_i = 5'd4; bus.rs1_used_i = 1'b1;
      #1;
      nchk++; if (bus.rs1_data_o !== 32'h44) begin
         nerr++; $display("FAIL squash_no_bypass got=%h exp=44", bus.rs1_data_o); end
      nchk++; if (bus.stall_o !== 1'b1) begin
         nerr++; $display("FAIL squash_hazard got=%b exp=1", bus.stall_o); end
      step();
      idle();
      bus.issue_valid_i = 1'b1;
      bus.rs1_addr_i = 5'd4; bus.rs1_used_i = 1'b1;
      #1;
      nchk++; if (bus.rs1_data_o !== 32'h44) begin
         nerr++; $display("FAIL squash_unchanged got=%h exp=44", bus.rs1_data_o); end
      nchk++; if (bus.stall_o !== 1'b0) begin
         nerr++; $display("FAIL squash_cnt_zero got=%b exp=0", bus.stall_o); end
      nchk++; if (bus.err_o !== 1'b0) begin
         nerr++; $display("FAIL squash_no_err got=%b exp=0", bus.err_o); end
      idle();
      retire(5'd4, 1'b0, 32'h0);
      step();
      idle();
      nchk++; if (bus.err_o !== 1'b1) begin
         nerr++; $display("FAIL underflow_err got=%b exp=1", bus.err_o); end
      step();
      step();
      nchk++; if (bus.err_o !== 1'b1) begin
         nerr++; $display("FAIL err_sticky got=%b exp=1", bus.err_o); end
   endtask

   task automatic test_reset_inflight();
      idle();
      issue(5'd2);
      step();
      step();
      idle();
      bus.issue_valid_i = 1'b1;
      bus.rs1_addr_i = 5'd2; bus.rs1_used_i = 1'b1;
      #1;
      nchk++; if (bus.stall_o !== 1'b1) begin
         nerr++; $display("FAIL inflight_stall got=%b exp=1", bus.stall_o); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      nchk++; if (bus.stall_o !== 1'b0) begin
         nerr++; $display("FAIL rst_clears_cnt got=%b exp=0", bus.stall_o); end
      nchk++; if (bus.err_o !== 1'b0) begin
         nerr++; $display("FAIL rst_clears_err got=%b exp=0", bus.err_o); end
      nchk++; if (bus.rs1_data_o !== '0) begin
         nerr++; $display("FAIL rst_clears_reg got=%h exp=0", bus.rs1_data_o); end
      idle();
      step();
   endtask

   task automatic test_random();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         bus.rs1_addr_i = 5'($urandom_range(0, 4)); bus.rs1_used_i = 1'($urandom);
         bus.rs2_addr_i = 5'($urandom_range(0, 4)); bus.rs2_used_i = 1'($urandom);
         bus.issue_valid_i = 1'($urandom); bus.issue_wr_i = ($urandom_range(0, 3) != 0);
         bus.issue_rd_i = 5'($urandom_range(0, 4));
         bus.wb_valid_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_rd_i = '0; bus.wb_data_i = $urandom;
         if (m_q.size() != 0 && $urandom_range(0, 2) != 0) begin
            bus.wb_valid_i = 1'b1; bus.wb_rd_i = m_q[0]; bus.wb_we_i = ($urandom_range(0, 3) != 0);
         end else if ($urandom_range(0, 9) == 0) begin
            bus.wb_valid_i = 1'b1; bus.wb_we_i = 1'b1;
         end
         #1;
         nchk++; if (bus.rs1_data_o !== m_read(bus.rs1_addr_i)) begin
            nerr++; $display("FAIL rand_rs1 cyc=%0d got=%h exp=%h", cyc, bus.rs1_data_o,
                             m_read(bus.rs1_addr_i)); end
         nchk++; if (bus.rs2_data_o !== m_read(bus.rs2_addr_i)) begin
            nerr++; $display("FAIL rand_rs2 cyc=%0d got=%h exp=%h", cyc, bus.rs2_data_o,
                             m_read(bus.rs2_addr_i)); end
         nchk++; if (bus.stall_o !== m_stall()) begin
            nerr++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, bus.stall_o,
                             m_stall()); end
         nchk++; if (bus.err_o !== m_err) begin
            nerr++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, bus.err_o, m_err); end
         step();
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      m_err = 1'b0;
      foreach (m_reg[i]) m_reg[i] = '0;
      idle();
      @(negedge clk);
      test_reset();
      test_bypass();
      test_raw();
      test_struct();
      test_squash();
      test_reset_inflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
